// File: rtl/ucode_loader_ctrl_if.sv
// Load-beat channel between the microcode source and the loader controller.
// The master supplies addressed words; the slave applies backpressure through ld_ready.
interface ucode_loader_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;

  modport master (
    output ld_valid, ld_sel, ld_addr, ld_data, ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_sel, ld_addr, ld_data, ld_last,
    output ld_ready
  );
endinterface

// File: rtl/ucode_loader_ctrl.sv
// Microcode loader/run controller: streams load beats into core instruction/data memory,
// then runs the core until it halts or the watchdog expires.
module ucode_loader_ctrl #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter int RUN_LIMIT  = 4096
) (
  input  logic                clk_x,
  input  logic                rst,
  ucode_loader_ctrl_if.slave  ld,
  input  logic                go,
  input  logic                halt,
  output logic [1:0]          mode,
  output logic [31:0]         w_addr,
  output logic [31:0]         in_data,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                addr_err,
  output logic [15:0]         word_cnt,
  output logic [31:0]         cyc_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_t;

  localparam logic [1:0]  MODE_RUN  = 2'b00;
  localparam logic [1:0]  MODE_DWR  = 2'b01;
  localparam logic [1:0]  MODE_IWR  = 2'b10;
  localparam logic [1:0]  MODE_HOLD = 2'b11;
  localparam logic [31:0] IMEM_TOP  = 32'(IMEM_DEPTH);
  localparam logic [31:0] DMEM_TOP  = 32'(DMEM_DEPTH);
  localparam logic [31:0] CYC_LAST  = 32'(RUN_LIMIT - 1);

  state_t state, state_next;
  logic   accept, in_range;
  logic   start_load, start_run, end_halt, end_wd;
  logic   wr_pend, wr_sel, last_pend;

  assign ld.ld_ready = (state != RUN);
  assign accept      = ld.ld_valid && ld.ld_ready;
  assign in_range    = ld.ld_sel ? (ld.ld_addr < DMEM_TOP) : (ld.ld_addr < IMEM_TOP);
  assign busy        = (state == LOAD) || (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_x or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    start_run  = 1'b0;
    end_halt   = 1'b0;
    end_wd     = 1'b0;
    case (state)
      IDLE, STOP: begin
        // A beat always wins over go in the same cycle.
        if (accept) begin
          state_next = LOAD;
          start_load = 1'b1;
        end else if (go) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      LOAD: begin
        // The cycle presenting the last beat's write ends the burst, unless a new one starts.
        if (last_pend) begin
          if (accept) start_load = 1'b1;
          else        state_next = IDLE;
        end
      end
      RUN: begin
        if (halt) begin
          state_next = STOP;
          end_halt   = 1'b1;
        end else if (cyc_cnt == CYC_LAST) begin
          state_next = STOP;
          end_wd     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mode = MODE_HOLD;
    if (state == RUN)  mode = MODE_RUN;
    else if (wr_pend)  mode = wr_sel ? MODE_DWR : MODE_IWR;
  end

  // NOTE: the async reset also clears wr_pend, so a write in flight is dropped, not replayed.
  always_ff @(posedge clk_x or negedge rst) begin
    if (!rst) begin
      wr_pend   <= 1'b0;
      wr_sel    <= 1'b0;
      last_pend <= 1'b0;
      w_addr    <= '0;
      in_data   <= '0;
      word_cnt  <= '0;
      cyc_cnt   <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      wr_pend   <= accept && in_range;
      last_pend <= accept && ld.ld_last;

      // Out-of-range beats leave the core write bus untouched.
      if (accept && in_range) begin
        wr_sel  <= ld.ld_sel;
        w_addr  <= ld.ld_addr;
        in_data <= ld.ld_data;
      end

      if (start_load) begin
        word_cnt <= in_range ? 16'd1 : 16'd0;
        addr_err <= !in_range;
        done     <= 1'b0;
        timeout  <= 1'b0;
      end else if (accept) begin
        if (!in_range)                 addr_err <= 1'b1;
        else if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
      end

      if (start_run) begin
        cyc_cnt <= '0;
        done    <= 1'b0;
        timeout <= 1'b0;
      end else if (state == RUN) begin
        cyc_cnt <= cyc_cnt + 32'd1;
        if (end_halt) done    <= 1'b1;
        if (end_wd)   timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ucode_loader_ctrl.sv
// Directed bench for ucode_loader_ctrl: default-parameter instance for load/run/reset cases,
// and a RUN_LIMIT=16 instance for the watchdog cases.
module tb_ucode_loader_ctrl;

  logic clk_x = 1'b0;
  logic rst;
  always #5 clk_x = ~clk_x;

  ucode_loader_ctrl_if ld_a ();
  ucode_loader_ctrl_if ld_b ();

  logic        go_a, halt_a, go_b, halt_b;
  logic [1:0]  mode_a, mode_b;
  logic [31:0] w_addr_a, in_data_a, w_addr_b, in_data_b;
  logic        busy_a, done_a, timeout_a, addr_err_a;
  logic        busy_b, done_b, timeout_b, addr_err_b;
  logic [15:0] word_cnt_a, word_cnt_b;
  logic [31:0] cyc_cnt_a, cyc_cnt_b;

  ucode_loader_ctrl dut_a (
    .clk_x(clk_x), .rst(rst), .ld(ld_a.slave), .go(go_a), .halt(halt_a),
    .mode(mode_a), .w_addr(w_addr_a), .in_data(in_data_a), .busy(busy_a),
    .done(done_a), .timeout(timeout_a), .addr_err(addr_err_a),
    .word_cnt(word_cnt_a), .cyc_cnt(cyc_cnt_a)
  );

  ucode_loader_ctrl #(.RUN_LIMIT(16)) dut_b (
    .clk_x(clk_x), .rst(rst), .ld(ld_b.slave), .go(go_b), .halt(halt_b),
    .mode(mode_b), .w_addr(w_addr_b), .in_data(in_data_b), .busy(busy_b),
    .done(done_b), .timeout(timeout_b), .addr_err(addr_err_b),
    .word_cnt(word_cnt_b), .cyc_cnt(cyc_cnt_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] burst_addr [7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd12};
  logic [31:0] burst_data [7] = '{32'hc0200001, 32'hc0400002, 32'h00611000, 32'h48830002,
                                  32'hc4800003, 32'hd0000005, 32'hffff0005};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_x);
    #1;
  endtask

  task automatic beat_a(input logic sel, input logic [31:0] addr, input logic [31:0] data,
                        input logic last);
    ld_a.ld_valid = 1'b1;
    ld_a.ld_sel   = sel;
    ld_a.ld_addr  = addr;
    ld_a.ld_data  = data;
    ld_a.ld_last  = last;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    go_a = 1'b0; halt_a = 1'b0; go_b = 1'b0; halt_b = 1'b0;
    ld_a.ld_valid = 1'b0; ld_a.ld_sel = 1'b0; ld_a.ld_addr = '0; ld_a.ld_data = '0; ld_a.ld_last = 1'b0;
    ld_b.ld_valid = 1'b0; ld_b.ld_sel = 1'b0; ld_b.ld_addr = '0; ld_b.ld_data = '0; ld_b.ld_last = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_mode",     32'(mode_a),     32'd3);
    check("rst_w_addr",   w_addr_a,        32'd0);
    check("rst_in_data",  in_data_a,       32'd0);
    check("rst_word_cnt", 32'(word_cnt_a), 32'd0);
    check("rst_cyc_cnt",  cyc_cnt_a,       32'd0);
    check("rst_flags",    32'({busy_a, done_a, timeout_a, addr_err_a}), 32'd0);
    check("rst_ready",    32'(ld_a.ld_ready), 32'd1);
    rst = 1'b1;

    // Seven-beat instruction burst, first beat on the first edge after reset release
    for (int i = 0; i < 7; i++) begin
      beat_a(1'b0, burst_addr[i], burst_data[i], i == 6);
      tick();
      check($sformatf("burst_mode_%0d", i),  32'(mode_a), 32'd2);
      check($sformatf("burst_addr_%0d", i),  w_addr_a,    burst_addr[i]);
      check($sformatf("burst_data_%0d", i),  in_data_a,   burst_data[i]);
      check($sformatf("burst_cnt_%0d", i),   32'(word_cnt_a), 32'(i + 1));
    end
    ld_a.ld_valid = 1'b0;
    check("burst_busy_last_wr", 32'(busy_a), 32'd1);
    tick();
    check("burst_end_mode",  32'(mode_a),     32'd3);
    check("burst_end_busy",  32'(busy_a),     32'd0);
    check("burst_end_cnt",   32'(word_cnt_a), 32'd7);
    check("burst_hold_addr", w_addr_a,        32'd12);
    check("burst_hold_data", in_data_a,       32'hffff0005);

    // Run, halt sampled at the end of the 20th run cycle
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    check("run_ready", 32'(ld_a.ld_ready), 32'd0);
    check("run_cyc0",  cyc_cnt_a,          32'd0);
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("run_mode_%0d", k), 32'(mode_a), 32'd0);
      if (k == 20) halt_a = 1'b1;
      tick();
    end
    halt_a = 1'b0;
    check("halt_mode",    32'(mode_a),    32'd3);
    check("halt_done",    32'(done_a),    32'd1);
    check("halt_timeout", 32'(timeout_a), 32'd0);
    check("halt_cyc",     cyc_cnt_a,      32'd20);
    check("halt_busy",    32'(busy_a),    32'd0);
    halt_a = 1'b1;
    tick();
    tick();
    halt_a = 1'b0;
    check("stop_cyc_hold",  cyc_cnt_a,   32'd20);
    check("stop_done_hold", 32'(done_a), 32'd1);
    check("stop_mode",      32'(mode_a), 32'd3);

    // Watchdog on the RUN_LIMIT=16 instance
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("wd_mode_%0d", k), 32'(mode_b), 32'd0);
      tick();
    end
    check("wd_timeout", 32'(timeout_b), 32'd1);
    check("wd_done",    32'(done_b),    32'd0);
    check("wd_mode",    32'(mode_b),    32'd3);
    check("wd_cyc",     cyc_cnt_b,      32'd16);

    // Halt and watchdog limit in the same cycle
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    check("wd2_timeout_clr", 32'(timeout_b), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) halt_b = 1'b1;
      tick();
    end
    halt_b = 1'b0;
    check("both_done",    32'(done_b),    32'd1);
    check("both_timeout", 32'(timeout_b), 32'd0);
    check("both_cyc",     cyc_cnt_b,      32'd16);

    // Out-of-range data beat, then a valid burst clears addr_err
    beat_a(1'b1, 32'd1024, 32'hdeadbeef, 1'b1);
    tick();
    ld_a.ld_valid = 1'b0;
    check("oor_mode",     32'(mode_a),     32'd3);
    check("oor_addr_err", 32'(addr_err_a), 32'd1);
    check("oor_word_cnt", 32'(word_cnt_a), 32'd0);
    check("oor_done_clr", 32'(done_a),     32'd0);
    check("oor_w_addr",   w_addr_a,        32'd12);
    tick();
    check("oor_idle", 32'(busy_a), 32'd0);
    beat_a(1'b1, 32'd1023, 32'h11111111, 1'b0);
    tick();
    check("dm_top_mode", 32'(mode_a),     32'd1);
    check("dm_top_addr", w_addr_a,        32'd1023);
    check("dm_err_clr",  32'(addr_err_a), 32'd0);
    check("dm_cnt1",     32'(word_cnt_a), 32'd1);
    beat_a(1'b1, 32'd5, 32'h22222222, 1'b1);
    tick();
    ld_a.ld_valid = 1'b0;
    check("dm2_mode", 32'(mode_a),     32'd1);
    check("dm2_data", in_data_a,       32'h22222222);
    check("dm2_cnt",  32'(word_cnt_a), 32'd2);
    tick();

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      beat_a(1'b0, 32'h10 + 32'(i), 32'h5000 + 32'(i), 1'b0);
      tick();
    end
    ld_a.ld_valid = 1'b0;
    check("mid_pre_mode", 32'(mode_a), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_mode", 32'(mode_a),     32'd3);
    check("mid_rst_cnt",  32'(word_cnt_a), 32'd0);
    check("mid_rst_cyc",  cyc_cnt_a,       32'd0);
    check("mid_rst_addr", w_addr_a,        32'd0);
    check("mid_rst_flags", 32'({busy_a, done_a, timeout_a, addr_err_a}), 32'd0);
    tick();
    rst = 1'b1;

    // Beat and go together in IDLE: beat wins; go held through LOAD is ignored
    beat_a(1'b0, 32'd7, 32'ha5a5a5a5, 1'b1);
    go_a = 1'b1;
    tick();
    ld_a.ld_valid = 1'b0;
    check("bg_mode", 32'(mode_a),     32'd2);
    check("bg_addr", w_addr_a,        32'd7);
    check("bg_cnt",  32'(word_cnt_a), 32'd1);
    check("bg_cyc",  cyc_cnt_a,       32'd0);
    tick();
    go_a = 1'b0;
    check("bg_end_mode", 32'(mode_a), 32'd3);
    check("bg_end_busy", 32'(busy_a), 32'd0);
    check("bg_end_cyc",  cyc_cnt_a,   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
